// File: rtl/gon_glb_writer_if.sv
// GON stream input and GLB write port bundle for gon_glb_writer.
// slave is the writer's view; master is the environment driving GON and the GLB ready.
interface gon_glb_writer_if #(
    parameter int unsigned DATA_BITS = 32,
    parameter int unsigned ADDR_BITS = 12
);
    logic                 GON_valid;
    logic                 GON_ready;
    logic [DATA_BITS-1:0] GON_data;
    logic                 glb_we;
    logic                 glb_ready;
    logic [ADDR_BITS-1:0] glb_addr;
    logic [DATA_BITS-1:0] glb_wdata;

    modport slave (
        input  GON_valid, GON_data, glb_ready,
        output GON_ready, glb_we, glb_addr, glb_wdata
    );

    modport master (
        output GON_valid, GON_data, glb_ready,
        input  GON_ready, glb_we, glb_addr, glb_wdata
    );
endinterface

// File: rtl/gon_glb_writer.sv
// Buffers a GON word stream through a small FIFO and writes it to consecutive GLB addresses.
// Optional macro GON_WR_RELU_EN clamps negative words to zero at the GLB write port.
module gon_glb_writer #(
    parameter int unsigned DATA_BITS  = 32,
    parameter int unsigned ADDR_BITS  = 12,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ADDR_BITS-1:0] base_addr,
    input  logic [15:0]          num_words,
    gon_glb_writer_if.slave      bus,
    output logic                 busy,
    output logic                 done
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;
    localparam int unsigned LEN_W = 16;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t               state_q, state_d;
    logic [ADDR_BITS-1:0] base_q;
    logic [LEN_W-1:0]     num_q, acc_cnt, wr_cnt, acc_nxt, wr_nxt;
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic [OCC_W-1:0]     occ;
    logic                 fifo_full, fifo_empty, active, start_acc;
    logic                 gon_ready_c, glb_we_c, push, pop;
    logic [DATA_BITS-1:0] head, wdata_c;

    assign fifo_full   = (occ == OCC_W'(FIFO_DEPTH));
    assign fifo_empty  = (occ == '0);
    assign active      = (state_q == RUN) || (state_q == DRAIN);
    assign start_acc   = (state_q == IDLE) && start;

    // GON_ready is a pure decode of registered state, never of GON_valid
    assign gon_ready_c = (state_q == RUN) && !fifo_full && (acc_cnt < num_q);
    assign glb_we_c    = active && !fifo_empty;
    assign push        = bus.GON_valid && gon_ready_c;
    assign pop         = glb_we_c && bus.glb_ready;
    assign acc_nxt     = acc_cnt + LEN_W'(push);
    assign wr_nxt      = wr_cnt + LEN_W'(pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Transitions look at next-cycle counts so done follows the last write by one cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = (num_words == '0) ? DONE : RUN;
            RUN:     if (acc_nxt == num_q) state_d = DRAIN;
            DRAIN:   if (wr_nxt == num_q) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            base_q  <= '0;
            num_q   <= '0;
            acc_cnt <= '0;
            wr_cnt  <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            occ     <= '0;
        end else begin
            if (start_acc) begin
                base_q  <= base_addr;
                num_q   <= num_words;
                acc_cnt <= '0;
                wr_cnt  <= '0;
            end else begin
                acc_cnt <= acc_nxt;
                wr_cnt  <= wr_nxt;
            end
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
        end
    end

    // Storage needs no reset: entries are only observable once written
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.GON_data;
    end

    assign head = mem[rd_ptr];

`ifdef GON_WR_RELU_EN
    assign wdata_c = head[DATA_BITS-1] ? '0 : head;
`else
    assign wdata_c = head;
`endif

    assign bus.GON_ready = gon_ready_c;
    assign bus.glb_we    = glb_we_c;
    assign bus.glb_addr  = base_q + ADDR_BITS'(wr_cnt);
    assign bus.glb_wdata = glb_we_c ? wdata_c : '0;
    assign busy          = active;
    assign done          = (state_q == DONE);
endmodule

// File: tb/tb_gon_glb_writer.sv
// Randomized self-checking bench for gon_glb_writer against a job-level reference model.
module tb_gon_glb_writer;
    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 12;
    localparam int unsigned DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [15:0]   num_words;
    logic          busy, done;

    gon_glb_writer_if #(.DATA_BITS(DW), .ADDR_BITS(AW)) bus ();

    gon_glb_writer #(.DATA_BITS(DW), .ADDR_BITS(AW), .FIFO_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .num_words (num_words),
        .bus       (bus),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    logic [DW-1:0] job_data [$];

    function automatic logic [DW-1:0] relu(input logic [DW-1:0] d);
`ifdef GON_WR_RELU_EN
        return d[DW-1] ? '0 : d;
`else
        return d;
`endif
    endfunction

    // One job: expected writes are base+i (mod 2^AW) carrying job_data[i] in order
    task automatic run_job(input logic [AW-1:0] base, input int n, input int vpct, input int rpct,
                           input int stall, input bit poke, input bit rel, input string name);
        logic [AW-1:0] got_a [$];
        logic [DW-1:0] got_d [$];
        int            push_cyc [$];
        int            acc = 0, wr = 0, first_wr = -1, last_wr = -1, done_cyc = -1, acc_stall = -1;
        int            exp_done;
        bit            beyond = 0, unstable = 0, lat_bad = 0, busy_bad = 0, hold = 0, post_ok;
        logic [AW-1:0] pa = '0, ea;
        logic [DW-1:0] pd = '0, ed;

        @(posedge clk); #1;
        if (rel) rst = 1'b1;
        start = 1'b1; base_addr = base; num_words = 16'(n);
        bus.GON_valid = 1'b0; bus.glb_ready = 1'b0;
        for (int c = 0; c < 400 && done_cyc < 0; c++) begin
            @(posedge clk); #1;
            start         = poke && (n > 0) && (c == 2);
            base_addr     = AW'($urandom);
            num_words     = 16'($urandom_range(1, 20));
            bus.GON_valid = int'($urandom_range(0, 99)) < vpct;
            bus.GON_data  = (acc < n) ? job_data[acc] : DW'($urandom);
            bus.glb_ready = (c < stall) ? 1'b0 : (int'($urandom_range(0, 99)) < rpct);
            @(negedge clk);
            if (bus.GON_ready === 1'b1 && acc >= n) beyond = 1;
            if (bus.GON_valid && bus.GON_ready === 1'b1) begin
                push_cyc.push_back(c);
                acc++;
            end
            if (hold && (bus.glb_we !== 1'b1 || bus.glb_addr !== pa || bus.glb_wdata !== pd)) unstable = 1;
            hold = (bus.glb_we === 1'b1) && !bus.glb_ready;
            pa = bus.glb_addr; pd = bus.glb_wdata;
            if (bus.glb_we === 1'b1 && bus.glb_ready) begin
                if (wr >= acc || push_cyc[wr] >= c) lat_bad = 1;
                got_a.push_back(bus.glb_addr);
                got_d.push_back(bus.glb_wdata);
                if (first_wr < 0) first_wr = c;
                last_wr = c;
                wr++;
            end
            if (stall > 0 && c == stall - 1) acc_stall = acc;
            if (busy !== ((n > 0) && done !== 1'b1)) busy_bad = 1;
            if (done === 1'b1) done_cyc = c;
        end
        @(posedge clk); #1;
        start = 1'b0; bus.GON_valid = 1'b0; bus.glb_ready = 1'b1;
        @(negedge clk);
        post_ok = (done === 1'b0) && (busy === 1'b0) && (bus.glb_we === 1'b0);

        n_vec++;
        if (done_cyc < 0) begin n_err++; $display("FAIL %s timeout: done not seen, writes=%0d", name, wr); end
        n_vec++;
        if (got_a.size() != n) begin n_err++; $display("FAIL %s write_count: got %0d want %0d", name, got_a.size(), n); end
        for (int i = 0; i < got_a.size() && i < n; i++) begin
            ea = base + AW'(i);
            ed = relu(job_data[i]);
            n_vec++;
            if (got_a[i] !== ea || got_d[i] !== ed) begin
                n_err++;
                $display("FAIL %s word[%0d]: got addr %h data %h want addr %h data %h", name, i, got_a[i], got_d[i], ea, ed);
            end
        end
        n_vec++;
        if (acc != n) begin n_err++; $display("FAIL %s accepted: got %0d want %0d", name, acc, n); end
        n_vec++;
        if (beyond || unstable || lat_bad || busy_bad) begin
            n_err++;
            $display("FAIL %s protocol: beyond=%0d unstable=%0d latency=%0d busy=%0d want all 0", name, beyond, unstable, lat_bad, busy_bad);
        end
        exp_done = (n == 0) ? 0 : last_wr + 1;
        n_vec++;
        if (done_cyc != exp_done) begin n_err++; $display("FAIL %s done_cycle: got %0d want %0d", name, done_cyc, exp_done); end
        n_vec++;
        if (!post_ok) begin n_err++; $display("FAIL %s after_done: done=%b busy=%b we=%b want 0 0 0", name, done, busy, bus.glb_we); end
        if (vpct == 100 && rpct == 100 && stall == 0 && n > 0) begin
            n_vec++;
            if (first_wr != 1 || last_wr - first_wr != n - 1) begin
                n_err++;
                $display("FAIL %s throughput: first=%0d last=%0d want first=1 last=%0d", name, first_wr, last_wr, n);
            end
        end
        if (stall > DEPTH && vpct == 100) begin
            n_vec++;
            if (acc_stall != ((n < DEPTH) ? n : DEPTH)) begin
                n_err++;
                $display("FAIL %s stall_fill: got %0d want %0d", name, acc_stall, (n < DEPTH) ? n : DEPTH);
            end
        end
    endtask

    task automatic fill_random(input int n);
        job_data.delete();
        for (int i = 0; i < n; i++) job_data.push_back(DW'($urandom));
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b1; base_addr = 12'h0AB; num_words = 16'd5;
        bus.GON_valid = 1'b1; bus.GON_data = DW'($urandom); bus.glb_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if ({bus.GON_ready, bus.glb_we, busy, done} !== 4'b0) begin
            n_err++; $display("FAIL reset_flags: got %b want 0000", {bus.GON_ready, bus.glb_we, busy, done});
        end
        n_vec++;
        if (bus.glb_addr !== '0 || bus.glb_wdata !== '0) begin
            n_err++; $display("FAIL reset_bus: got addr %h data %h want 0 0", bus.glb_addr, bus.glb_wdata);
        end
        start = 1'b0; bus.GON_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        n_vec++;
        if (busy !== 1'b0 || bus.GON_ready !== 1'b0) begin
            n_err++; $display("FAIL reset_release_idle: busy=%b gon_ready=%b want 0 0", busy, bus.GON_ready);
        end
    endtask

    task automatic test_basic();
        job_data.delete();
        job_data.push_back(32'h11); job_data.push_back(32'h22);
        job_data.push_back(32'h33); job_data.push_back(32'h44);
        run_job(12'h010, 4, 100, 100, 0, 1'b0, 1'b0, "basic");
    endtask

    task automatic test_backpressure();
        fill_random(8);
        run_job(AW'($urandom), 8, 100, 100, 10, 1'b0, 1'b0, "backpressure");
    endtask

    task automatic test_wrap();
        fill_random(3);
        run_job(12'hFFE, 3, 100, 100, 0, 1'b0, 1'b0, "wrap");
    endtask

    task automatic test_zero_len();
        job_data.delete();
        run_job(12'h123, 0, 100, 100, 0, 1'b0, 1'b0, "zero_len");
    endtask

    task automatic test_relu();
        job_data.delete();
        job_data.push_back(32'hFFFF_FFF0); job_data.push_back(32'h0000_0005);
        run_job(12'h200, 2, 100, 100, 0, 1'b0, 1'b0, "relu");
    endtask

    task automatic test_random();
        int n;
        for (int k = 0; k < 8; k++) begin
            n = int'($urandom_range(1, 12));
            fill_random(n);
            run_job(AW'($urandom), n, int'($urandom_range(40, 100)), int'($urandom_range(30, 100)),
                    (k % 3 == 0) ? int'($urandom_range(1, 6)) : 0, k[0], 1'b0, "random");
        end
    endtask

    task automatic test_reset_mid_job();
        int acc = 0, wr = 0, extra = 0;
        fill_random(6);
        @(posedge clk); #1;
        start = 1'b1; base_addr = 12'h300; num_words = 16'd6;
        bus.GON_valid = 1'b1; bus.glb_ready = 1'b1;
        for (int c = 0; c < 40 && wr < 2; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            bus.GON_data = job_data[(acc < 6) ? acc : 0];
            @(negedge clk);
            if (bus.GON_valid && bus.GON_ready === 1'b1) acc++;
            if (bus.glb_we === 1'b1 && bus.glb_ready) wr++;
        end
        n_vec++;
        if (wr != 2) begin n_err++; $display("FAIL midreset_reach: got %0d writes want 2", wr); end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        n_vec++;
        if (bus.glb_we !== 1'b0 || busy !== 1'b0 || bus.GON_ready !== 1'b0 || bus.glb_wdata !== '0) begin
            n_err++;
            $display("FAIL midreset_immediate: we=%b busy=%b gon_ready=%b wdata=%h want 0 0 0 0", bus.glb_we, busy, bus.GON_ready, bus.glb_wdata);
        end
        repeat (3) begin
            @(negedge clk);
            if (bus.glb_we !== 1'b0) extra++;
        end
        n_vec++;
        if (extra != 0) begin n_err++; $display("FAIL midreset_no_writes: got %0d want 0", extra); end
        fill_random(1);
        run_job(AW'($urandom), 1, 100, 100, 0, 1'b0, 1'b1, "after_reset");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap();
        test_zero_len();
        test_relu();
        test_random();
        test_reset_mid_job();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/gon_glb_writer.md
GON_GLB_WRITER -- requirements
Module: gon_glb_writer

Interface
REQ-001 The module SHALL have parameter DATA_BITS, default 32, meaning the GON and GLB data word width.
REQ-002 The module SHALL have parameter ADDR_BITS, default 12, meaning the GLB word-address width.
REQ-003 The module SHALL have parameter FIFO_DEPTH, default 4, meaning the internal buffer entries (power of two, at least 2).
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 The module SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 The module SHALL have port start, input, 1 bit: a one-cycle pulse that launches a write-back job.
REQ-007 The module SHALL have port base_addr, input, ADDR_BITS: the first GLB word address of the job, sampled on an accepted start.
REQ-008 The module SHALL have port num_words, input, 16 bits: the number of words in the job, sampled on an accepted start.
REQ-009 The module SHALL have ports GON_valid (input, 1), GON_ready (output, 1) and GON_data (input, DATA_BITS): the slave side of the GON output.
REQ-010 The module SHALL have ports glb_we (output, 1), glb_ready (input, 1), glb_addr (output, ADDR_BITS) and glb_wdata (output, DATA_BITS): the GLB write port.
REQ-011 The module SHALL have ports busy (output, 1) and done (output, 1): job status.

Function
REQ-012 The state machine SHALL have four states, IDLE, RUN, DRAIN and DONE; busy SHALL be 1 in RUN and DRAIN, and 0 otherwise.
REQ-013 In IDLE, a start pulse SHALL latch base_addr and num_words, clear both counters, and enter RUN when num_words is nonzero or DONE when num_words is 0.
REQ-014 A start pulse outside IDLE SHALL be ignored.
REQ-015 GON_ready SHALL equal (state==RUN) && !fifo_full && (acc_cnt < num_words); GON_ready SHALL NOT depend on GON_valid.
REQ-016 A GON transfer SHALL occur when GON_valid && GON_ready; on a transfer, GON_data is pushed into the FIFO and acc_cnt increments.
REQ-017 When acc_cnt reaches num_words, RUN SHALL move to DRAIN on the following cycle.
REQ-018 glb_we SHALL equal (state is RUN or DRAIN) && !fifo_empty, and glb_wdata SHALL be the FIFO head.
REQ-019 glb_addr SHALL equal (base_addr + wr_cnt) modulo 2^ADDR_BITS, so addresses wrap silently.
REQ-020 A GLB write SHALL complete when glb_we && glb_ready; on completion the FIFO pops and wr_cnt increments.
REQ-021 While glb_ready is 0, glb_we, glb_addr and glb_wdata SHALL hold stable.
REQ-022 A push and a pop in the same cycle SHALL leave the occupancy unchanged; a push is never allowed while the FIFO is full.
REQ-023 Minimum latency SHALL be one cycle: data accepted in cycle N is presented on glb_we no earlier than cycle N+1.
REQ-024 With glb_ready held at 1, throughput SHALL be one word per cycle.
REQ-025 In DRAIN, when wr_cnt reaches num_words, the FSM SHALL enter DONE.
REQ-026 DONE SHALL last exactly one cycle, with done=1, then return to IDLE.
REQ-027 done SHALL be 0 in every state other than DONE.
REQ-028 Words arriving on GON beyond num_words SHALL NOT be accepted, because GON_ready is 0.

Reset
REQ-029 While rst=0, the FSM SHALL be forced to IDLE asynchronously.
REQ-030 While rst=0, the FIFO SHALL be emptied and acc_cnt and wr_cnt cleared.
REQ-031 While rst=0, GON_ready, glb_we, busy and done SHALL be 0, and glb_addr and glb_wdata SHALL be 0.
REQ-032 Assertion of rst mid-job SHALL abandon the job with no further GLB writes; buffered words are discarded.
REQ-033 Release of rst SHALL be treated synchronously to clk, and the first start SHALL be accepted in the first cycle after release.

Configuration
REQ-034 When GON_WR_RELU_EN is defined, glb_wdata SHALL be the FIFO head with negative values (bit DATA_BITS-1 set, two's complement) replaced by 0, applied combinationally at the write port with no added latency.
REQ-035 When GON_WR_RELU_EN is undefined, glb_wdata SHALL be the FIFO head unmodified, and no ReLU logic SHALL be synthesized.

Verification
REQ-036 Basic job: base_addr=0x010, num_words=4, GON streams 0x11..0x44 back-to-back, glb_ready=1 -> writes at 0x010..0x013 with data 0x11..0x44 in order, a done pulse one cycle after the last write, and busy low afterwards.
REQ-037 Backpressure: glb_ready=0 for 10 cycles with num_words=8 -> GON_ready drops after FIFO_DEPTH words are accepted; glb_addr and glb_wdata stay stable; after release all 8 words are written in order with none lost.
REQ-038 Wrap and zero length: base_addr=0xFFE, num_words=3 -> addresses 0xFFE, 0xFFF, 0x000; separately, num_words=0 -> done one cycle after start, with no glb_we and GON_ready never 1.
REQ-039 Reset mid-job: rst=0 after 2 of 6 words are written -> glb_we=0 immediately; after release a new start with num_words=1 completes normally.
REQ-040 ReLU: with GON_WR_RELU_EN defined, GON_data 0xFFFFFFF0 -> glb_wdata 0x00000000, and GON_data 0x00000005 -> glb_wdata 0x00000005; undefined -> 0xFFFFFFF0 is passed through unchanged.
